// File: rtl/denorm_shift_if.sv
// denorm_shift_if: start/busy/done handshake and data bus of the denormalizing shifter.
// The master drives the request (start, value, shift count).
// The slave returns the reconstructed value and the status flags.
interface denorm_shift_if #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int CW = 5
);
    logic          start_i;
    logic [DW-1:0] y_i;
    logic [CW-1:0] shift_i;
    logic [AW-1:0] data_o;
    logic          busy_o;
    logic          done_o;
    logic          ovf_o;

    modport master (
        output start_i, y_i, shift_i,
        input  data_o, busy_o, done_o, ovf_o
    );

    modport slave (
        input  start_i, y_i, shift_i,
        output data_o, busy_o, done_o, ovf_o
    );
endinterface

// File: rtl/denorm_shift.sv
// denorm_shift: rebuilds a wide value from a normalized DW-bit value and the
// shift count recorded at normalization time. It shifts left one bit per clock.
//
// Sequence: IDLE -> SHIFT -> DONE -> IDLE.
// All outputs come straight from registers.
//
// Optional build macro DENORM_SAT_EN:
//   - Defined: the first lost set bit saturates the accumulator to all ones.
//   - Undefined: the result wraps modulo 2^AW.
//   - In both builds ovf_o reports the loss and the latency is unchanged.
module denorm_shift #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int CW = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    denorm_shift_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] acc_r, acc_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          ovf_r, ovf_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    // One shifting step of the accumulator.
    // ovf_seen indicates that a set bit has already been lost in this operation.
    function automatic logic [AW-1:0] shift_step(input logic [AW-1:0] acc,
                                                 input logic          ovf_seen);
        logic [AW-1:0] res;
`ifdef DENORM_SAT_EN
        if (ovf_seen) begin
            // Already saturated: hold all ones for the remaining counts.
            res = acc;
        end else if (acc[AW-1]) begin
            res = {AW{1'b1}};
        end else begin
            res = {acc[AW-2:0], 1'b0};
        end
`else
        if (ovf_seen) begin
            res = {acc[AW-2:0], 1'b0};
        end else begin
            res = {acc[AW-2:0], 1'b0};
        end
`endif
        return res;
    endfunction

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    acc_s          = {AW{1'b0}};
                    acc_s[DW-1:0]  = bus.y_i;
                    cnt_s          = bus.shift_i;
                    ovf_s          = 1'b0;
                    busy_s         = 1'b1;
                    state_s        = ST_SHIFT;
                end else begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    acc_s  = shift_step(acc_r, ovf_r);
                    cnt_s  = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    ovf_s  = ovf_r | acc_r[AW-1];
                    busy_s = 1'b1;
                end
            end
            ST_DONE: begin
                // The start request is deliberately ignored here, which forces one idle cycle.
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers. The asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            acc_r   <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.data_o = acc_r;
    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign bus.ovf_o  = ovf_r;

endmodule

// File: tb/tb_denorm_shift.sv
// tb_denorm_shift: scoreboard bench for denorm_shift.
// The driver pushes the expected {data, ovf, done cycle, busy length} for each
// accepted start. A negedge monitor pops an entry and compares it on every done_o pulse.
module tb_denorm_shift;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int CW = 5;

    typedef struct {
        logic [AW-1:0] data;
        logic          ovf;
        int            done_cyc;
        int            busy_len;
    } exp_t;

    logic clk_i;
    logic rst_i;
    int   cyc;
    int   n_chk;
    int   n_pass;
    exp_t sb_q[$];

    denorm_shift_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    denorm_shift #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the value times 2^shift as wide arithmetic.
    // Any bit above the output width counts as an overflow.
    function automatic exp_t model(input logic [DW-1:0] y, input int sh, input int k);
        exp_t e;
        logic [63:0] full;
        full = 64'(y) * (64'd1 << sh);
        e.ovf = (full >> AW) != 64'd0;
        e.data = full[AW-1:0];
`ifdef DENORM_SAT_EN
        if (e.ovf) e.data = {AW{1'b1}};
`endif
        e.done_cyc = k + sh + 1;
        e.busy_len = sh + 1;
        return e;
    endfunction

    // Monitor: compares each done_o pulse with the oldest expectation.
    int  busy_run;
    logic prev_busy;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            busy_run  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.busy_o) busy_run = prev_busy ? busy_run + 1 : 1;
            prev_busy = bus.busy_o;
            if (bus.done_o) begin
                if (sb_q.size() == 0) begin
                    check("stray_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("data_o", 64'(bus.data_o), 64'(e.data));
                    check("ovf_o", 64'(bus.ovf_o), 64'(e.ovf));
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("busy_len", 64'(busy_run), 64'(e.busy_len));
                    check("busy_in_done", 64'(bus.busy_o), 64'd0);
                end
            end
        end
    end

    // Returns just after a negedge at which the DUT was idle (neither busy nor done).
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (!bus.busy_o && !bus.done_o) return;
        end
        check("idle_timeout", 64'd1, 64'd0);
    endtask

    // Issues one request. When push is set, the expected response is queued.
    task automatic issue(input logic [DW-1:0] y, input int sh, input bit push);
        wait_idle();
        bus.start_i = 1'b1;
        bus.y_i     = y;
        bus.shift_i = CW'(sh);
        if (push) sb_q.push_back(model(y, sh, cyc + 1));
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        bus.y_i     = DW'($urandom);
        bus.shift_i = CW'($urandom);
    endtask

    initial begin
        int k0;
        logic [DW-1:0] yr;
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        rst_i = 1'b0;
        bus.start_i = 1'b0;
        bus.y_i = '0;
        bus.shift_i = '0;
        #23;
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_ovf", 64'(bus.ovf_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Directed cases, including the zero-shift and full-count boundaries.
        issue(16'h4000, 4, 1);
        issue(16'h8001, 0, 1);
        issue(16'hFFFF, 20, 1);
        issue(16'h0000, 31, 1);
        issue(16'hFFFF, 31, 1);
        issue(16'h0001, 31, 1);

        // A start pulse while busy is ignored and must not yield a second done.
        issue(16'h0001, 10, 1);
        repeat (2) @(posedge clk_i);
        #1;
        bus.start_i = 1'b1;
        bus.y_i = 16'h1234;
        bus.shift_i = 5'd3;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;

        // An asynchronous reset in mid-operation clears all outputs at once and produces no done.
        issue(16'hABCD, 12, 0);
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("abort_data", 64'(bus.data_o), 64'd0);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_done", 64'(bus.done_o), 64'd0);
        check("abort_ovf", 64'(bus.ovf_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        issue(16'h0003, 1, 1);

        // With start held high, requests are accepted every shift+3 cycles.
        wait_idle();
        yr = DW'($urandom);
        k0 = cyc + 1;
        bus.start_i = 1'b1;
        bus.y_i = yr;
        bus.shift_i = 5'd2;
        for (int i = 0; i < 3; i++) sb_q.push_back(model(yr, 2, k0 + 5 * i));
        do begin
            @(posedge clk_i);
            #1;
        end while (cyc < k0 + 10);
        bus.start_i = 1'b0;

        // Randomized requests with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            int sh;
            sh = int'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: yr = 16'h0000;
                1: yr = 16'hFFFF;
                default: yr = DW'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            issue(yr, sh, 1);
        end

        wait_idle();
        repeat (3) @(negedge clk_i);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
